noc_requant_stream: RTL and testbench
=====================================

// Module: noc_requant_stream
// PURPOSE
//  Streaming requantiser between the MM core output and the write DMA of the attention projection path.
//  Converts each int32 accumulator lane to int8 as follows: multiply by a fixed-point multiplier, apply a rounded arithmetic right shift, add the zero point, then saturate.
//  Processes one Q'/K'/V' tile per run. The run is armed by start and reports completion to the projection FSM.
// PARAMETERS
//  LANES    4   int elements per stream beat
//  ACC_W    32  signed accumulator width per lane
//  OUT_W    8   signed output width per lane
//  MULT_W   16  signed requant multiplier width
//  SHIFT_W  6   right-shift amount width (0..47 used)
//  CNT_W    20  beat counter width
// PORTS
//  clk            in   1              clock
//  rstn           in   1              async active-low reset
//  start          in   1              arm a run (tied to start_dma_out at COMPUTE entry)
//  num_beats      in   CNT_W          beats in this tile, sampled on start
//  cfg_mult       in   MULT_W         signed multiplier, sampled on start
//  cfg_shift      in   SHIFT_W        right shift, sampled on start
//  cfg_zp         in   OUT_W          signed zero point, sampled on start
//  s_axis_tdata   in   LANES*ACC_W    accumulators from MM core; lane0 = LSBs
//  s_axis_tvalid  in   1
//  s_axis_tlast   in   1
//  s_axis_tready  out  1
//  m_axis_tdata   out  LANES*OUT_W    int8 results to write DMA
//  m_axis_tvalid  out  1
//  m_axis_tlast   out  1
//  m_axis_tready  in   1
//  busy           out  1              high from start accept until DONE
//  done           out  1              level; high in DONE until next accepted start (requant_done)
//  error          out  1              sticky per run: input tlast mismatch
//  sat_count      out  CNT_W          saturated elements this run; saturates at max
// BEHAVIOUR
//  Reset values: all outputs 0; FSM = IDLE; pipeline valids cleared.
//  FSM states:
//   - IDLE: start -> latch cfg, clear counters, error and sat_count, go to RUN.
//   - DONE: start -> same as IDLE.
//   - RUN: s_axis_tready = pipe_en. Leave RUN when in_cnt == num_beats.
//     num_beats = 0 -> go straight to DRAIN, then DONE; no beats are accepted.
//   - DRAIN: s_axis_tready = 0; go to DONE when out_cnt == num_beats.
//   - DONE: done = 1, busy = 0.
//   - start in RUN or DRAIN is ignored.
//  Pipeline: 3 stages, stall-all, pipe_en = m_axis_tready | ~v3.
//   - S1: prod = acc * mult, signed, ACC_W+MULT_W bits.
//   - S2: r = (prod + (shift ? 1<<(shift-1) : 0)) >>> shift.
//   - S3: y = r + zp, then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   - Latency: input beat accepted at cycle t -> m_axis_tvalid at t+3 if there are no stalls.
//   - Throughput: 1 beat/cycle.
//   - Stages hold their data while pipe_en = 0; m_axis_tdata is stable while tvalid && !tready.
//  m_axis_tlast is generated from out_cnt == num_beats-1 and does not depend on s_axis_tlast.
//  error is set when either:
//   - s_axis_tlast = 1 on an accepted beat with in_cnt != num_beats-1, or
//   - s_axis_tlast = 0 on the final accepted beat.
//   The data path still processes the beat. error clears on the next accepted start.
//  sat_count adds the number of lanes clipped in S3 when S3 advances; it holds at all-ones.
//  Async reset mid-run: discards in-flight beats and returns to IDLE. No output beat is emitted after reset.
// STRUCTURE
//  Shared package (noc_pkg): requant FSM state encoding, LANES/ACC_W/OUT_W defaults, saturation helper function.
//  Sub-module: noc_requant_lane (one lane of S1-S3 with a clip flag), generated LANES times.
//  Top level holds the FSM, counters, valid pipeline and tlast logic.
// TESTING
//  1. mult=1, shift=0, zp=0, num_beats=4, acc={3,-5,127,-128} -> output identical, tlast on beat 3, done=1, sat_count=0.
//  2. mult=3, shift=2, zp=10, acc=7 -> 7*3=21, (21+2)>>2=5, +10 = 15. acc=-7 -> (-21+2)>>>2 = -5, +10 = 5.
//  3. mult=1000, shift=0, zp=0, acc={1000,-1000,0,1} -> {127,-128,0,127}, sat_count=3.
//  4. num_beats=64, m_axis_tready random 50% -> 64 beats in order, data stable under stall, error=0, done after last beat.
//  5. s_axis_tlast on beat 2 of 4 -> error=1, all 4 beats still output, tlast on beat 3. Next start clears error.
//  6. Assert rstn=0 after 10 of 32 beats -> all outputs 0 next cycle. New start with num_beats=0 -> done within 3 cycles, no m_axis beat.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC requantiser: FSM encoding, default widths
// and the generic signed saturation helper.
package noc_pkg;

   localparam int RQ_LANES = 4;
   localparam int RQ_ACC_W = 32;
   localparam int RQ_OUT_W = 8;

   typedef enum logic [1:0] {
      RQ_IDLE  = 2'd0,
      RQ_RUN   = 2'd1,
      RQ_DRAIN = 2'd2,
      RQ_DONE  = 2'd3
   } rq_state_e;

   // Clamp a wide signed value into the range of a w-bit signed integer.
   function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] v,
                                                    input int unsigned      w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage

// File: rtl/noc_requant_lane.sv
// One requant lane: multiply (S1), rounded arithmetic shift (S2), zero point
// add and saturation with a clip flag (S3). All stages advance together on en.
module noc_requant_lane
   import noc_pkg::*;
#(
   parameter int ACC_W   = RQ_ACC_W,
   parameter int MULT_W  = 16,
   parameter int SHIFT_W = 6,
   parameter int OUT_W   = RQ_OUT_W
) (
   input  logic                      clk,
   input  logic                      en,
   input  logic signed [ACC_W-1:0]   acc,
   input  logic signed [MULT_W-1:0]  mult,
   input  logic        [SHIFT_W-1:0] shift,
   input  logic signed [OUT_W-1:0]   zp,
   output logic signed [OUT_W-1:0]   y,
   output logic                      clip
);

   localparam int PW = ACC_W + MULT_W;
   // One guard bit so the rounding bias cannot overflow the largest product.
   localparam int RW = PW + 1;

   logic signed [PW-1:0]    prod_p1;
   logic signed [RW-1:0]    r_p2;
   logic signed [OUT_W-1:0] y_p3;
   logic                    clip_p3;
   logic signed [63:0]      sum_s3;
   logic signed [63:0]      sat_s3;

   function automatic logic signed [RW-1:0] round_shift(input logic signed [PW-1:0]  p,
                                                         input logic [SHIFT_W-1:0] s);
      logic signed [RW-1:0] pe;
      logic signed [RW-1:0] bias;
      pe   = RW'(p);
      bias = (s == '0) ? '0 : (RW'(1) <<< (s - SHIFT_W'(1)));
      return (pe + bias) >>> s;
   endfunction

   always_comb begin
      sum_s3 = 64'(r_p2) + 64'(zp);
      sat_s3 = sat_to_w(sum_s3, OUT_W);
   end

   always_ff @(posedge clk) begin
      if (en) begin
         // S1: full-precision product
         prod_p1 <= PW'(acc) * PW'(mult);
         // S2: round half up, then arithmetic shift
         r_p2    <= round_shift(prod_p1, shift);
         // S3: zero point and clip to the output range
         y_p3    <= sat_s3[OUT_W-1:0];
         clip_p3 <= (sat_s3 != sum_s3);
      end
   end

   assign y    = y_p3;
   assign clip = clip_p3;

endmodule

// File: rtl/noc_requant_stream.sv
// Streaming int32 -> int8 requantiser for one projection tile per run:
// run FSM, beat counters, stall-all valid pipeline and output tlast.
module noc_requant_stream
   import noc_pkg::*;
#(
   parameter int LANES   = RQ_LANES,
   parameter int ACC_W   = RQ_ACC_W,
   parameter int OUT_W   = RQ_OUT_W,
   parameter int MULT_W  = 16,
   parameter int SHIFT_W = 6,
   parameter int CNT_W   = 20
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     start,
   input  logic [CNT_W-1:0]         num_beats,
   input  logic signed [MULT_W-1:0] cfg_mult,
   input  logic [SHIFT_W-1:0]       cfg_shift,
   input  logic signed [OUT_W-1:0]  cfg_zp,
   input  logic [LANES*ACC_W-1:0]   s_axis_tdata,
   input  logic                     s_axis_tvalid,
   input  logic                     s_axis_tlast,
   output logic                     s_axis_tready,
   output logic [LANES*OUT_W-1:0]   m_axis_tdata,
   output logic                     m_axis_tvalid,
   output logic                     m_axis_tlast,
   input  logic                     m_axis_tready,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [CNT_W-1:0]         sat_count
);

   rq_state_e                state;
   logic [CNT_W-1:0]         nb_r;
   logic [CNT_W-1:0]         in_cnt;
   logic [CNT_W-1:0]         out_cnt;
   logic signed [MULT_W-1:0] mult_r;
   logic [SHIFT_W-1:0]       shift_r;
   logic signed [OUT_W-1:0]  zp_r;
   logic                     vld_p1;
   logic                     vld_p2;
   logic                     vld_p3;
   logic                     pipe_en;
   logic                     in_acc;
   logic                     out_hs;
   logic                     in_last;
   logic                     start_ok;
   logic [LANES*OUT_W-1:0]   y_all;
   logic [LANES-1:0]         clip_all;
   logic [CNT_W-1:0]         n_clip;
   logic [CNT_W:0]           sat_sum;

   assign pipe_en       = m_axis_tready | ~vld_p3;
   assign s_axis_tready = (state == RQ_RUN) && pipe_en && (in_cnt != nb_r);
   assign in_acc        = s_axis_tvalid & s_axis_tready;
   assign out_hs        = vld_p3 & m_axis_tready;
   assign in_last       = (in_cnt == nb_r - CNT_W'(1));
   assign start_ok      = start && ((state == RQ_IDLE) || (state == RQ_DONE));

   assign m_axis_tvalid = vld_p3;
   assign m_axis_tdata  = vld_p3 ? y_all : '0;
   assign m_axis_tlast  = vld_p3 && (out_cnt == nb_r - CNT_W'(1));

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      noc_requant_lane #(
         .ACC_W   (ACC_W),
         .MULT_W  (MULT_W),
         .SHIFT_W (SHIFT_W),
         .OUT_W   (OUT_W)
      ) u_lane (
         .clk   (clk),
         .en    (pipe_en),
         .acc   (s_axis_tdata[l*ACC_W +: ACC_W]),
         .mult  (mult_r),
         .shift (shift_r),
         .zp    (zp_r),
         .y     (y_all[l*OUT_W +: OUT_W]),
         .clip  (clip_all[l])
      );
   end

   always_comb begin
      n_clip = '0;
      for (int l = 0; l < LANES; l++)
         n_clip = n_clip + CNT_W'(clip_all[l]);
      sat_sum = {1'b0, sat_count} + {1'b0, n_clip};
   end

   // Run configuration is only consumed while a run is active.
   always_ff @(posedge clk) begin
      if (start_ok) begin
         mult_r  <= cfg_mult;
         shift_r <= cfg_shift;
         zp_r    <= cfg_zp;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= RQ_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         sat_count <= '0;
         nb_r      <= '0;
         in_cnt    <= '0;
         out_cnt   <= '0;
         vld_p1    <= 1'b0;
         vld_p2    <= 1'b0;
         vld_p3    <= 1'b0;
      end else begin
         if (pipe_en) begin
            vld_p1 <= in_acc;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
         end
         if (in_acc) begin
            in_cnt <= in_cnt + CNT_W'(1);
            if (s_axis_tlast != in_last)
               error <= 1'b1;
         end
         if (out_hs) begin
            out_cnt   <= out_cnt + CNT_W'(1);
            sat_count <= sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
         end
         case (state)
            RQ_IDLE, RQ_DONE: begin
               if (start) begin
                  state     <= RQ_RUN;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  error     <= 1'b0;
                  sat_count <= '0;
                  in_cnt    <= '0;
                  out_cnt   <= '0;
                  nb_r      <= num_beats;
               end
            end
            RQ_RUN: begin
               if (in_cnt == nb_r)
                  state <= RQ_DRAIN;
            end
            RQ_DRAIN: begin
               if (out_cnt == nb_r) begin
                  state <= RQ_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= RQ_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_requant_stream.sv
// Directed bench for noc_requant_stream with a queue-based arithmetic model
// and a per-cycle output checker.
module tb_noc_requant_stream;

   localparam int LANES = 4;
   localparam int ACC_W = 32;
   localparam int OUT_W = 8;
   localparam int CNT_W = 20;

   logic                   clk = 1'b0;
   logic                   rstn;
   logic                   start;
   logic [CNT_W-1:0]       num_beats;
   logic [15:0]            cfg_mult;
   logic [5:0]             cfg_shift;
   logic [7:0]             cfg_zp;
   logic [LANES*ACC_W-1:0] s_axis_tdata;
   logic                   s_axis_tvalid;
   logic                   s_axis_tlast;
   logic                   s_axis_tready;
   logic [LANES*OUT_W-1:0] m_axis_tdata;
   logic                   m_axis_tvalid;
   logic                   m_axis_tlast;
   logic                   m_axis_tready;
   logic                   busy;
   logic                   done;
   logic                   error;
   logic [CNT_W-1:0]       sat_count;

   noc_requant_stream dut (
      .clk           (clk),
      .rstn          (rstn),
      .start         (start),
      .num_beats     (num_beats),
      .cfg_mult      (cfg_mult),
      .cfg_shift     (cfg_shift),
      .cfg_zp        (cfg_zp),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .sat_count     (sat_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          g_nb, g_mult, g_shift, g_zp;
   int          out_idx = 0;
   int          exp_sat = 0;
   bit          rand_rdy = 0;
   bit          lat_chk  = 0;
   bit          prev_stall = 0;
   logic [31:0] prev_data;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, expv, $time);
      end
   endtask

   function automatic logic [127:0] mk(input int a0, input int a1, input int a2, input int a3);
      return {a3, a2, a1, a0};
   endfunction

   // Reference: y = sat8(round(acc*mult / 2^shift) + zp), rounding half toward +inf.
   function automatic logic [31:0] model_y(input logic [127:0] acc, input int mult,
                                           input int shift, input int zp, output int nclip);
      logic [31:0] o;
      longint a, p, y;
      nclip = 0;
      o = '0;
      for (int l = 0; l < LANES; l++) begin
         a = longint'(signed'(acc[l*32 +: 32]));
         p = a * longint'(mult);
         if (shift > 0) p = (p + (longint'(1) <<< (shift - 1))) >>> shift;
         y = p + longint'(zp);
         if (y > 127) begin y = 127; nclip++; end
         else if (y < -128) begin y = -128; nclip++; end
         o[l*8 +: 8] = y[7:0];
      end
      return o;
   endfunction

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!rstn) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", m_axis_tvalid, 1);
            check("stall_data", m_axis_tdata, prev_data);
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", m_axis_tvalid, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_data", m_axis_tdata, e.data);
               check("out_last", m_axis_tlast, (out_idx == g_nb - 1));
               if (lat_chk) check("latency", cyc - e.cyc, 3);
               out_idx++;
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
      end
   end

   task automatic do_start(input int nb, input int mult, input int shift, input int zp);
      @(posedge clk); #1;
      g_nb = nb; g_mult = mult; g_shift = shift; g_zp = zp;
      out_idx = 0; exp_sat = 0;
      num_beats = nb[CNT_W-1:0];
      cfg_mult  = mult[15:0];
      cfg_shift = shift[5:0];
      cfg_zp    = zp[7:0];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [127:0] acc, input logic last);
      int   budget;
      bit   took;
      int   nc;
      exp_t x;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = acc;
      s_axis_tlast  = last;
      budget = 400;
      took   = 0;
      while (!took && budget > 0) begin
         @(negedge clk);
         if (s_axis_tready) begin
            took   = 1;
            x.data = model_y(acc, g_mult, g_shift, g_zp, nc);
            x.cyc  = cyc;
            exp_q.push_back(x);
            exp_sat += nc;
         end
         @(posedge clk); #1;
         budget--;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (!took) check("accept_timeout", s_axis_tready, 1);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mvalid"}, m_axis_tvalid, 0);
      check({tag, "_mdata"}, m_axis_tdata, 0);
      check({tag, "_mlast"}, m_axis_tlast, 0);
      check({tag, "_sready"}, s_axis_tready, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_satcnt"}, sat_count, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nc;
      rstn = 1'b0; start = 1'b0; num_beats = '0;
      cfg_mult = '0; cfg_shift = '0; cfg_zp = '0;
      s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;

      // Pin the model to hand-computed values.
      check("model_t1", model_y(mk(3, -5, 127, -128), 1, 0, 0, nc), 32'h807FFB03);
      check("model_t2", model_y(mk(7, -7, 0, 0), 3, 2, 10, nc), 32'h0A0A050F);
      check("model_t3", model_y(mk(1000, -1000, 0, 1), 1000, 0, 0, nc), 32'h7F00807F);
      check("model_t3_clip", nc, 3);

      repeat (3) @(posedge clk); #1;
      check_all_zero("reset");
      @(negedge clk); rstn = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset");

      // Test 1: identity requant, latency 3
      lat_chk = 1;
      do_start(4, 1, 0, 0);
      check("t1_busy", busy, 1);
      send_beat(mk(3, -5, 127, -128), 1'b0);
      send_beat(mk(-128, 127, -5, 3), 1'b0);
      send_beat(mk(0, 1, -1, 64), 1'b0);
      send_beat(mk(3, -5, 127, -128), 1'b1);
      wait_done("t1", 40);
      lat_chk = 0;
      check("t1_satcnt", sat_count, 0);
      check("t1_error", error, 0);
      check("t1_drained", exp_q.size(), 0);

      // Test 2: multiply, round, zero point
      do_start(2, 3, 2, 10);
      send_beat(mk(7, -7, 0, 0), 1'b0);
      send_beat(mk(-7, 7, 100, -100), 1'b1);
      wait_done("t2", 40);
      check("t2_satcnt", sat_count, exp_sat);
      check("t2_error", error, 0);

      // Test 3: saturation both directions
      do_start(1, 1000, 0, 0);
      send_beat(mk(1000, -1000, 0, 1), 1'b1);
      wait_done("t3", 40);
      check("t3_satcnt", sat_count, 3);

      // Test 4: long tile under random backpressure
      rand_rdy = 1;
      do_start(64, -300, 12, -3);
      for (int i = 0; i < 64; i++)
         send_beat(mk(i*53 - 1700, i*53 - 1200, i*53 - 700, i*53 - 200), (i == 63));
      wait_done("t4", 2000);
      rand_rdy = 0;
      check("t4_error", error, 0);
      check("t4_satcnt", sat_count, exp_sat);
      check("t4_drained", exp_q.size(), 0);

      // Test 5: early input tlast raises error, all beats still flow
      do_start(4, 1, 0, 0);
      for (int i = 0; i < 4; i++)
         send_beat(mk(i, -i, 10*i, -10*i), (i == 1));
      wait_done("t5", 40);
      check("t5_error", error, 1);
      check("t5_drained", exp_q.size(), 0);
      do_start(1, 2, 1, 0);
      check("t5_error_clear", error, 0);
      send_beat(mk(5, -5, 1, -1), 1'b1);
      wait_done("t5b", 40);
      check("t5b_error", error, 0);

      // Test 6: reset mid-run, then an empty tile
      do_start(32, 1, 0, 0);
      for (int i = 0; i < 10; i++)
         send_beat(mk(i, i + 1, i + 2, i + 3), 1'b0);
      rstn = 1'b0;
      #1;
      check_all_zero("t6_reset");
      exp_q.delete();
      @(negedge clk);
      check_all_zero("t6_reset_hold");
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      check("t6_idle_mvalid", m_axis_tvalid, 0);
      do_start(0, 1, 0, 0);
      wait_done("t6_empty", 3);
      check("t6_empty_mvalid", m_axis_tvalid, 0);
      check("t6_empty_satcnt", sat_count, 0);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
